// File: rtl/iir_out_collector_pkg.sv
// rtl/iir_out_collector_pkg.sv - shared types and constants for the filter output collector
package iir_out_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NB_DEFAULT = 10;
    localparam int AW_DEFAULT = 4;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int FIFO_DEPTH_DEFAULT = fifo_depth(AW_DEFAULT);

endpackage

// File: rtl/iir_out_collector_if.sv
// rtl/iir_out_collector_if.sv - sample stream in, pull-side read and status out
interface iir_out_collector_if
    import iir_out_collector_pkg::*;
#(
    parameter int Nb = NB_DEFAULT,
    parameter int AW = AW_DEFAULT,
    parameter int CW = 16
);
    logic [Nb-1:0] DIN;
    logic          VIN;
    logic          RD_REQ;
    logic [Nb-1:0] DOUT;
    logic          VOUT;
    logic          EMPTY;
    logic          FULL;
    logic [AW:0]   LEVEL;
    logic          OVF;
    logic [CW-1:0] CNT;
    logic          DONE;

    modport master (
        output DIN, VIN, RD_REQ,
        input  DOUT, VOUT, EMPTY, FULL, LEVEL, OVF, CNT, DONE
    );

    modport slave (
        input  DIN, VIN, RD_REQ,
        output DOUT, VOUT, EMPTY, FULL, LEVEL, OVF, CNT, DONE
    );
endinterface

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - circular sample store with registered level/empty/full
module iir_sync_fifo
    import iir_out_collector_pkg::*;
#(
    parameter int W  = NB_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [AW:0]  level,
    output logic         empty,
    output logic         full
);
    localparam int DEPTH = fifo_depth(AW);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  level_nxt;
    logic         wr_ok;
    logic         rd_ok;

    // Flags are taken as they stood at cycle start, so a pop never frees room for a same-cycle push.
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        level_nxt = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_nxt = level + (AW+1)'(1);
            2'b01:   level_nxt = level - (AW+1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
            level <= level_nxt;
            empty <= (level_nxt == '0);
            full  <= (level_nxt == {1'b1, {AW{1'b0}}});
        end
    end
endmodule

// File: rtl/iir_out_collector.sv
// rtl/iir_out_collector.sv - captures IIR output samples, serves pops, detects end of stream
module iir_out_collector
    import iir_out_collector_pkg::*;
#(
    parameter int Nb       = NB_DEFAULT,
    parameter int AW       = AW_DEFAULT,
    parameter int CW       = 16,
    parameter int IDLE_MAX = 8
) (
    input logic                CLK,
    input logic                RST_n,
    input logic                CLR,
    iir_out_collector_if.slave bus
);
    localparam logic [7:0] IDLE_LIM = 8'(IDLE_MAX);

    state_t        state;
    logic [7:0]    idle_cnt;
    logic [7:0]    idle_inc;
    logic [Nb-1:0] dout_q;
    logic          vout_q;
    logic          ovf_q;
    logic [CW-1:0] cnt_q;
    logic          done_q;
    logic [Nb-1:0] fifo_q;
    logic [AW:0]   level;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign push     = bus.VIN & ~full;
    assign pop      = bus.RD_REQ & ~empty;
    assign idle_inc = idle_cnt + 8'd1;

    iir_sync_fifo #(.W(Nb), .AW(AW)) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_n),
        .clr     (CLR),
        .wr_en   (push),
        .wr_data (bus.DIN),
        .rd_en   (pop),
        .rd_data (fifo_q),
        .level   (level),
        .empty   (empty),
        .full    (full)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (CLR) begin
            state    <= ST_IDLE;
            idle_cnt <= '0;
            dout_q   <= '0;
            vout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            vout_q <= pop;
            if (pop) dout_q <= fifo_q;
            if (push && cnt_q != '1) cnt_q <= cnt_q + CW'(1);
            if (bus.VIN && full) ovf_q <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (push) begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.VIN) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_LIM) begin
                        idle_cnt <= idle_inc;
                        if (idle_inc == IDLE_LIM) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (bus.VIN) begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                    end else if (empty) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.VIN) begin
                        state    <= ST_ACTIVE;
                        idle_cnt <= '0;
                        done_q   <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.DOUT  = dout_q;
    assign bus.VOUT  = vout_q;
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.LEVEL = level;
    assign bus.OVF   = ovf_q;
    assign bus.CNT   = cnt_q;
    assign bus.DONE  = done_q;
endmodule
